// File: rtl/mmio_timer_if.sv
// mmio_timer_if
// Bus bundle between the memory block's address decoder and the timer.
// Built with -DTIMER_CMP_EN, the timer also uses cmp_wr/irq_clr and drives irq.
// Without that macro, cmp_wr/irq_clr are ignored and irq stays 0.
//
// Signals:
//   us_wr     decoder -> timer  load strobe for us_count
//   ms_wr     decoder -> timer  load strobe for ms_count
//   wr_data   decoder -> timer  32-bit load value shared by all strobes
//   cmp_wr    decoder -> timer  load strobe for the ms compare register
//   irq_clr   decoder -> timer  clears the sticky compare flag
//   us_count  timer -> decoder  microsecond counter
//   ms_count  timer -> decoder  millisecond counter
//   us_tick   timer -> decoder  pulse in the cycle us_count shows a new increment
//   ms_tick   timer -> decoder  pulse in the cycle ms_count shows a new increment
//   irq       timer -> decoder  sticky compare-match flag
interface mmio_timer_if;
    logic        us_wr;
    logic        ms_wr;
    logic [31:0] wr_data;
    logic        cmp_wr;
    logic        irq_clr;
    logic [31:0] us_count;
    logic [31:0] ms_count;
    logic        us_tick;
    logic        ms_tick;
    logic        irq;

    modport master (
        output us_wr, ms_wr, wr_data, cmp_wr, irq_clr,
        input  us_count, ms_count, us_tick, ms_tick, irq
    );

    modport slave (
        input  us_wr, ms_wr, wr_data, cmp_wr, irq_clr,
        output us_count, ms_count, us_tick, ms_tick, irq
    );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer
// Free-running microsecond and millisecond counters that back the memory-mapped
// timer words. The system clock is divided by a prescaler into 1 us ticks.
// The us ticks are divided by a sub-counter into 1 ms ticks.
// Software may reload either counter at any time.
//
// Optional feature macro: TIMER_CMP_EN
//   When defined, it adds a 32-bit ms compare register and a sticky irq flag.
//   When undefined, irq is tied 0 and cmp_wr/irq_clr are ignored.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high reset, dominant over every strobe
//   bus    mmio_timer_if.slave: strobes/data in, counters/ticks/irq out
//
// Parameters:
//   CLK_FREQ_HZ  system clock in Hz, an integer multiple of 1 MHz, >= 2 MHz
//   US_PER_MS    microsecond ticks per millisecond, >= 2
module mmio_timer #(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int US_PER_MS   = 1000
) (
    input  logic         clk,
    input  logic         reset,
    mmio_timer_if.slave  bus
);

    localparam int US_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PRE_W  = $clog2(US_DIV);
    localparam int SUB_W  = $clog2(US_PER_MS);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(US_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(US_PER_MS - 1);

    if ((CLK_FREQ_HZ % 1_000_000) != 0 || CLK_FREQ_HZ < 2_000_000) begin : gBadClk
        $error("mmio_timer: CLK_FREQ_HZ must be a multiple of 1000000 and at least 2000000");
    end
    if (US_PER_MS < 2) begin : gBadUsPerMs
        $error("mmio_timer: US_PER_MS must be at least 2");
    end

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [31:0]      usCount_q, usCount_d;
    logic [31:0]      msCount_q, msCount_d;
    logic             usTick_q, usTick_d;
    logic             msTick_q, msTick_d;
    logic             irq_q;

    logic preWrap;
    logic subWrap;

    // The prescaler wrap marks the end of each microsecond.
    // The sub-counter wrap only happens on a prescaler wrap.
    // A load of a counter suppresses that counter's increment and tick.
    // A load does not stop the other stage of the chain from advancing.
    // So a us load that lands on a wrap still lets sub advance and fire ms_tick.
    always_comb begin
        preWrap   = (pre_q == PRE_LAST);
        subWrap   = preWrap && (sub_q == SUB_LAST);

        pre_d     = preWrap ? '0 : pre_q + PRE_W'(1);
        usCount_d = usCount_q + {31'd0, preWrap};
        usTick_d  = preWrap;
        if (bus.us_wr) begin
            pre_d     = '0;
            usCount_d = bus.wr_data;
            usTick_d  = 1'b0;
        end

        sub_d     = sub_q;
        if (preWrap) begin
            sub_d = subWrap ? '0 : sub_q + SUB_W'(1);
        end
        msCount_d = msCount_q + {31'd0, subWrap};
        msTick_d  = subWrap;
        if (bus.ms_wr) begin
            sub_d     = '0;
            msCount_d = bus.wr_data;
            msTick_d  = 1'b0;
        end
    end

    // Timebase registers. Reset clears everything regardless of strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= '0;
            sub_q     <= '0;
            usCount_q <= '0;
            msCount_q <= '0;
            usTick_q  <= 1'b0;
            msTick_q  <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            sub_q     <= sub_d;
            usCount_q <= usCount_d;
            msCount_q <= msCount_d;
            usTick_q  <= usTick_d;
            msTick_q  <= msTick_d;
        end
    end

`ifdef TIMER_CMP_EN
    logic [31:0] cmp_q;
    logic        irq_d;
    logic        msChanged;

    // The compare fires whenever ms_count takes a new value equal to cmp.
    // Both increments and loads count, even when a load rewrites the same value.
    // A set beats a simultaneous clear, so a pending match is never lost.
    always_comb begin
        msChanged = bus.ms_wr || subWrap;
        irq_d     = irq_q;
        if (bus.irq_clr) begin
            irq_d = 1'b0;
        end
        if (msChanged && (msCount_d == cmp_q)) begin
            irq_d = 1'b1;
        end
    end

    // Compare register and sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q <= '0;
            irq_q <= 1'b0;
        end else begin
            if (bus.cmp_wr) begin
                cmp_q <= bus.wr_data;
            end
            irq_q <= irq_d;
        end
    end
`else
    logic unusedCmpInputs;

    // Without the compare feature the compare strobes have no effect.
    // The irq flag is a constant 0.
    assign unusedCmpInputs = bus.cmp_wr ^ bus.irq_clr;
    assign irq_q           = 1'b0;
`endif

    assign bus.us_count = usCount_q;
    assign bus.ms_count = msCount_q;
    assign bus.us_tick  = usTick_q;
    assign bus.ms_tick  = msTick_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer
// Self-checking bench for mmio_timer at the default 12 MHz / 1000 us-per-ms.
// The bench keeps a behavioural model of the timer. The model counts elapsed
// clocks and elapsed microseconds as plain integers. Every cycle, the DUT
// outputs are compared against that model. Directed steps also compare
// against hand-computed constants.
module tb_mmio_timer;

    localparam int CLK_HZ = 12_000_000;
    localparam int US_DIV = CLK_HZ / 1_000_000;
    localparam int US_MS  = 1000;
`ifdef TIMER_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    mmio_timer_if bus ();

    mmio_timer #(
        .CLK_FREQ_HZ (CLK_HZ),
        .US_PER_MS   (US_MS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state.
    // clkInUs: clock edges into the current microsecond.
    // usInMs:  microseconds into the current millisecond.
    int unsigned clkInUs;
    int unsigned usInMs;
    logic [31:0] mUs, mMs, mCmp;
    logic        mUsTick, mMsTick, mIrq;

    // Free-running system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one rising edge, using the inputs presented at that edge.
    task automatic modelEdge();
        bit          usDone, msDone, msChanged;
        logic [31:0] nextMs;
        if (reset) begin
            clkInUs = 0; usInMs = 0;
            mUs = '0; mMs = '0; mCmp = '0;
            mUsTick = 1'b0; mMsTick = 1'b0; mIrq = 1'b0;
            return;
        end
        usDone  = ((clkInUs + 1) % US_DIV) == 0;
        msDone  = usDone && (((usInMs + 1) % US_MS) == 0);
        clkInUs = bus.us_wr ? 0 : (clkInUs + 1) % US_DIV;
        if (bus.ms_wr) usInMs = 0;
        else if (usDone) usInMs = (usInMs + 1) % US_MS;
        mUsTick   = usDone && !bus.us_wr;
        mUs       = bus.us_wr ? bus.wr_data : mUs + (usDone ? 32'd1 : 32'd0);
        mMsTick   = msDone && !bus.ms_wr;
        nextMs    = bus.ms_wr ? bus.wr_data : mMs + (msDone ? 32'd1 : 32'd0);
        msChanged = bus.ms_wr || msDone;
        if (CMP_EN) begin
            if (msChanged && nextMs == mCmp) mIrq = 1'b1;
            else if (bus.irq_clr) mIrq = 1'b0;
            if (bus.cmp_wr) mCmp = bus.wr_data;
        end
        mMs = nextMs;
    endtask

    // Compare a single observed value against a bench-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the reference model.
    task automatic checkAll();
        logic [66:0] obs, exp;
        obs = {bus.us_count, bus.ms_count, bus.us_tick, bus.ms_tick, bus.irq};
        exp = {mUs, mMs, mUsTick, mMsTick, mIrq};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL model_cycle%0d observed=%h expected=%h", cycle, obs, exp);
        end
    endtask

    // One rising edge; model update; check the outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        cycle++;
        checkAll();
    endtask

    // Present strobes and data. This is called at the falling edge.
    task automatic applyStimulus(input bit usWr, input bit msWr, input logic [31:0] data,
                                 input bit cmpWr, input bit irqClr);
        bus.us_wr   = usWr;
        bus.ms_wr   = msWr;
        bus.wr_data = data;
        bus.cmp_wr  = cmpWr;
        bus.irq_clr = irqClr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int usTicks;
        int msTicks;
        logic [31:0] data;

        reset = 1'b1;
        idle();
        @(negedge clk);

        // Reset state.
        repeat (2) tick();
        checkOutput("rst_us", bus.us_count, 32'h0);
        checkOutput("rst_ms", bus.ms_count, 32'h0);
        checkOutput("rst_us_tick", {31'd0, bus.us_tick}, 32'h0);
        checkOutput("rst_ms_tick", {31'd0, bus.ms_tick}, 32'h0);
        checkOutput("rst_irq", {31'd0, bus.irq}, 32'h0);

        // First microsecond arrives exactly 12 edges after release.
        reset   = 1'b0;
        usTicks = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.us_tick) usTicks++;
            if (i == 11) checkOutput("us_before_first", bus.us_count, 32'h0);
        end
        checkOutput("first_us", bus.us_count, 32'd1);
        checkOutput("first_us_tick", {31'd0, bus.us_tick}, 32'd1);
        checkOutput("us_tick_once", usTicks, 32'd1);
        checkOutput("first_us_ms", bus.ms_count, 32'h0);

        // First millisecond at edge 12000.
        msTicks = 0;
        for (int i = 13; i <= 12000; i++) begin
            tick();
            if (bus.ms_tick) msTicks++;
        end
        checkOutput("first_ms", bus.ms_count, 32'd1);
        checkOutput("first_ms_us", bus.us_count, 32'd1000);
        checkOutput("first_ms_tick", {31'd0, bus.ms_tick}, 32'd1);
        checkOutput("ms_tick_once", msTicks, 32'd1);

        // us counter wraps from all ones to zero.
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("us_load_max", bus.us_count, 32'hFFFF_FFFF);
        checkOutput("us_load_no_tick", {31'd0, bus.us_tick}, 32'h0);
        repeat (11) tick();
        checkOutput("us_max_hold", bus.us_count, 32'hFFFF_FFFF);
        tick();
        checkOutput("us_wrap_zero", bus.us_count, 32'h0);
        checkOutput("us_wrap_tick", {31'd0, bus.us_tick}, 32'd1);

        // Load both counters together; this also realigns both prescaler stages.
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("ms_load", bus.ms_count, 32'h1234_5678);
        checkOutput("us_load_pair", bus.us_count, 32'h1234_5678);
        repeat (11999) tick();
        checkOutput("ms_load_hold", bus.ms_count, 32'h1234_5678);
        tick();
        checkOutput("ms_load_inc", bus.ms_count, 32'h1234_5679);
        checkOutput("ms_load_us", bus.us_count, 32'h1234_5A60);
        checkOutput("ms_load_tick", {31'd0, bus.ms_tick}, 32'd1);

        // A us load on the wrapping edge beats the increment.
        repeat (11) tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_0064, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("load_beats_inc", bus.us_count, 32'h64);
        checkOutput("load_beats_tick", {31'd0, bus.us_tick}, 32'h0);
        repeat (11) tick();
        checkOutput("after_collide_hold", bus.us_count, 32'h64);
        tick();
        checkOutput("after_collide_inc", bus.us_count, 32'h65);

        // Reset mid-prescale at us_count = 500.
        applyStimulus(1'b1, 1'b0, 32'd499, 1'b0, 1'b0);
        tick();
        idle();
        repeat (12) tick();
        checkOutput("us_at_500", bus.us_count, 32'd500);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_us", bus.us_count, 32'h0);
        checkOutput("mid_rst_ms", bus.ms_count, 32'h0);
        checkOutput("mid_rst_tick", {30'd0, bus.us_tick, bus.ms_tick}, 32'h0);
        repeat (11) tick();
        checkOutput("restart_hold", bus.us_count, 32'h0);
        tick();
        checkOutput("restart_us", bus.us_count, 32'd1);
        checkOutput("restart_tick", {31'd0, bus.us_tick}, 32'd1);

        // Compare match at ms_count = 5. irq is 0 throughout without the feature.
        applyStimulus(1'b0, 1'b0, 32'd5, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'd3, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("cmp_wr_no_irq", {31'd0, bus.irq}, 32'h0);
        repeat (23999) tick();
        checkOutput("ms_before_cmp", bus.ms_count, 32'd4);
        checkOutput("irq_before_cmp", {31'd0, bus.irq}, 32'h0);
        tick();
        checkOutput("ms_at_cmp", bus.ms_count, 32'd5);
        checkOutput("irq_at_cmp", {31'd0, bus.irq}, {31'd0, CMP_EN});
        repeat (3) tick();
        checkOutput("irq_sticky", {31'd0, bus.irq}, {31'd0, CMP_EN});
        applyStimulus(1'b0, 1'b1, 32'd5, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("irq_set_beats_clr", {31'd0, bus.irq}, {31'd0, CMP_EN});
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("irq_cleared", {31'd0, bus.irq}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'd5, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("cmp_rewrite_no_irq", {31'd0, bus.irq}, 32'h0);

        // Randomized strobes. Every cycle is checked against the model.
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: data = mMs + 32'($urandom_range(0, 2));
                5:             data = 32'hFFFF_FFFF;
                default:       data = $urandom;
            endcase
            reset = ($urandom_range(0, 399) == 0);
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0), data,
                          ($urandom_range(0, 29) == 0), ($urandom_range(0, 24) == 0));
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
